// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with level valid/ack handshake, overrun and framing-error flags.
// Optional build macro UART_RX_MAJORITY_EN: each decision uses a 2-of-3 vote over recent ticks.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sample_tick_i,
  input  logic       rx_i,
  input  logic       rx_ack_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       rx_busy_o
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StFlush
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] tick_cnt_q;
  logic [2:0]      bit_index_q;
  logic [7:0]      sr_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            rx_busy_q;
  logic            sample;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two previous tick samples; the live rx_s_q is the third vote.
  logic [1:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist_q <= 2'b11;
    end else if (sample_tick_i) begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign sample = rx_s_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_index_q <= '0;
      sr_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (rx_ack_i) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (sample_tick_i) begin
        case (state_q)
          StIdle: begin
            if (!rx_s_q) begin
              state_q    <= StStart;
              tick_cnt_q <= '0;
              rx_busy_q  <= 1'b1;
            end
          end
          StStart: begin
            if (tick_cnt_q == HalfLast) begin
              tick_cnt_q <= '0;
              if (!sample) begin
                state_q     <= StData;
                bit_index_q <= '0;
              end else begin
                state_q   <= StIdle;
                rx_busy_q <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CntOne;
            end
          end
          StData: begin
            if (tick_cnt_q == FullLast) begin
              tick_cnt_q <= '0;
              sr_q       <= {sample, sr_q[7:1]};
              if (bit_index_q == 3'd7) begin
                state_q <= StStop;
              end else begin
                bit_index_q <= bit_index_q + 3'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CntOne;
            end
          end
          StStop: begin
            if (tick_cnt_q == FullLast) begin
              tick_cnt_q <= '0;
              if (sample) begin
                rx_data_q  <= sr_q;
                rx_valid_q <= 1'b1;
                // A same-cycle ack consumed the old byte, so nothing was lost.
                overrun_q  <= ~rx_ack_i & (overrun_q | rx_valid_q);
                state_q    <= StIdle;
                rx_busy_q  <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StFlush;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CntOne;
            end
          end
          StFlush: begin
            if (rx_s_q) begin
              state_q   <= StIdle;
              rx_busy_q <= 1'b0;
            end
          end
          default: begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            rx_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign rx_busy_o   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames with a tick every 4 clocks and checks against a byte-level model.
module tb_uart_rx;

  localparam int unsigned Os      = 16;
  localparam int          BitClks = Os * 4;
  // Frame starts on a tick edge P0: detection at P4, stop-bit decision at P4 + 152 ticks.
  localparam int          DoneClk = 4 + (Os / 2 + 9 * Os) * 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       rx_busy_o;

  int unsigned clk_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          fe_cnt = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  int         m_fe;

  uart_rx #(.OVERSAMPLE(Os)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .sample_tick_i(sample_tick),
    .rx_i         (rx),
    .rx_ack_i     (rx_ack),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .rx_busy_o    (rx_busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;
  assign sample_tick = (clk_cnt % 4 == 0);

  always @(negedge clk) if (frame_err_o === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves us #1 after a tick edge, which becomes P0 of the next frame.
  task automatic align();
    while (clk_cnt % 4 != 1) step();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"}, {24'd0, rx_data_o}, {24'd0, m_data});
    check({tag, "_valid"}, {31'd0, rx_valid_o}, {31'd0, m_valid});
    check({tag, "_ovr"}, {31'd0, overrun_o}, {31'd0, m_ovr});
    check({tag, "_ferr"}, fe_cnt, m_fe);
  endtask

  // Byte-level consequences of one frame, from the handshake rules alone.
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack_at_end);
    if (stop) begin
      m_ovr   = ack_at_end ? 1'b0 : (m_ovr | m_valid);
      m_valid = 1'b1;
      m_data  = d;
    end else begin
      m_fe++;
      if (ack_at_end) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop, input int glitch_at,
                             input int ack_at, input int abort_at,
                             output logic v_pre, output logic v_post);
    logic [9:0] bits;
    logic       g;
    bits   = {stop, d, 1'b0};
    v_pre  = 1'bx;
    v_post = 1'bx;
    align();
    for (int i = 0; i < 10 * BitClks; i++) begin
      if (i == abort_at) begin
        reset  = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        step();
        reset = 1'b0;
        return;
      end
      g      = (glitch_at >= 0) && (i >= glitch_at) && (i < glitch_at + 4);
      rx     = bits[i / BitClks] ^ g;
      rx_ack = (i == ack_at);
      if (i == DoneClk - 1) v_pre = rx_valid_o;
      if (i == DoneClk) v_post = rx_valid_o;
      step();
    end
    rx_ack = 1'b0;
  endtask

  logic [7:0] d;
  logic       stop;
  logic       vp;
  logic       vq;
  int         mode;
  int         gap;

  initial begin
    rx      = 1'b1;
    rx_ack  = 1'b0;
    reset   = 1'b1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_fe    = 0;
    repeat (3) step();
    reset = 1'b0;
    check_model("rst");
    check("rst_busy", {31'd0, rx_busy_o}, 32'd0);
    check("rst_ferr_pin", {31'd0, frame_err_o}, 32'd0);
    idle(20);

    // Single good frame, exact completion edge.
    drive_frame(8'hA5, 1'b1, -1, -1, -1, vp, vq);
    model_frame(8'hA5, 1'b1, 1'b0);
    check("a5_pre_edge", {31'd0, vp}, 32'd0);
    check("a5_post_edge", {31'd0, vq}, 32'd1);
    check_model("a5");
    check("a5_busy", {31'd0, rx_busy_o}, 32'd0);
    ack_pulse();
    check_model("a5_ack");

    // Back-to-back without ack gives overrun.
    drive_frame(8'h3C, 1'b1, -1, -1, -1, vp, vq);
    model_frame(8'h3C, 1'b1, 1'b0);
    drive_frame(8'hC3, 1'b1, -1, -1, -1, vp, vq);
    model_frame(8'hC3, 1'b1, 1'b0);
    check_model("b2b");
    ack_pulse();
    check_model("b2b_ack");

    // Ack in the same cycle as the second completion.
    drive_frame(8'h11, 1'b1, -1, -1, -1, vp, vq);
    model_frame(8'h11, 1'b1, 1'b0);
    drive_frame(8'h22, 1'b1, -1, DoneClk - 1, -1, vp, vq);
    model_frame(8'h22, 1'b1, 1'b1);
    check("coin_pre_edge", {31'd0, vp}, 32'd1);
    check_model("coin");

    // False start: 4 ticks low.
    align();
    rx = 1'b0;
    repeat (16) step();
    rx = 1'b1;
    check("fstart_busy", {31'd0, rx_busy_o}, 32'd1);
    idle(BitClks);
    check("fstart_idle", {31'd0, rx_busy_o}, 32'd0);
    check_model("fstart");

    // Bad stop followed by a break of 3 bit times.
    drive_frame(8'h55, 1'b0, -1, -1, -1, vp, vq);
    model_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * BitClks) step();
    check("break_busy", {31'd0, rx_busy_o}, 32'd1);
    check_model("break");
    idle(32);
    check("break_exit", {31'd0, rx_busy_o}, 32'd0);
    check_model("break_end");

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      mode = $urandom_range(0, 2);
      drive_frame(d, stop, -1, (mode == 1) ? DoneClk - 1 : -1, -1, vp, vq);
      model_frame(d, stop, mode == 1);
      if (!stop) idle(32);
      check("rnd_busy", {31'd0, rx_busy_o}, 32'd0);
      check_model("rnd");
      if (mode == 2) ack_pulse();
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40);
      idle(gap);
    end

    // Make sure there is something for reset to clear.
    drive_frame(8'h9E, 1'b1, -1, -1, -1, vp, vq);
    model_frame(8'h9E, 1'b1, 1'b0);
    drive_frame(8'hFF, 1'b1, -1, -1, 5 * BitClks + 20, vp, vq);
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    check_model("abort");
    check("abort_busy", {31'd0, rx_busy_o}, 32'd0);
    check("abort_ferr_pin", {31'd0, frame_err_o}, 32'd0);
    idle(BitClks);

`ifdef UART_RX_MAJORITY_EN
    // One-tick glitch landing on the bit-3 decision tick.
    drive_frame(8'h0F, 1'b1, 4 + (Os / 2) * 4 + 4 * BitClks - 3, -1, -1, vp, vq);
`else
    drive_frame(8'h0F, 1'b1, -1, -1, -1, vp, vq);
`endif
    model_frame(8'h0F, 1'b1, 1'b0);
    check_model("post_rst");
    check("post_rst_busy", {31'd0, rx_busy_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
